exc_ctrl: RTL

- Exception/interrupt sequencer beside the write-back stage.
- Each cycle it takes the exception flags of the instruction in WB plus the external interrupt lines, and picks one event by fixed priority.
- It drives the CP0 exception-commit controls and a multi-cycle pipeline flush.
- It then hands the redirect target (exception vector or EPC) to fetch over a valid/ready handshake. WB commits nothing while a flush is in flight.

---
 rtl/exc_ctrl_if.sv | 22 ++
 rtl/exc_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl_if.sv
// Redirect handshake between the exception sequencer and fetch.
//   redirect_valid : sequencer has a redirect target ready
//   redirect_pc    : redirect target, held stable while valid
//   redirect_ready : fetch accepts the target
// master = exc_ctrl, slave = fetch.
interface exc_ctrl_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception / interrupt sequencer beside the write-back stage.
// Picks one event per cycle by fixed priority from the WB exception flags,
// eret and pending interrupts, commits it to CP0 combinationally, flushes
// the pipeline for FLUSH_CYCLES cycles, then hands the redirect target
// (EXC_VEC or EPC) to fetch over a valid/ready handshake.
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   ws_*                   WB instruction state and exception flags
//   c0_*                   CP0 Status / Cause / EPC state
//   wb_*                   one-cycle CP0 commit controls
//   exc_flush, ws_block    pipeline flush and WB write suppression
//   redir (master)         redirect_valid / redirect_pc / redirect_ready
//   exc_count, int_count   event statistics (only with EXC_CTRL_STAT_EN)
//
// Optional feature macro: EXC_CTRL_STAT_EN adds saturating 16-bit counters
// of committed exceptions and of interrupts.
//
// state       | meaning
// ST_IDLE     | sampling WB; an event commits and starts the flush
// ST_FLUSH    | flush continues until FLUSH_CYCLES flush-high cycles
// ST_REDIRECT | target offered to fetch until accepted
module exc_ctrl #(
  parameter logic [31:0] EXC_VEC      = 32'hbfc00380,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic        ws_bd,
  input  logic [31:0] ws_data_addr,
  input  logic        ws_ex_adel_if,
  input  logic        ws_ex_ri,
  input  logic        ws_ex_ov,
  input  logic        ws_ex_sys,
  input  logic        ws_ex_bp,
  input  logic        ws_ex_adel,
  input  logic        ws_ex_ades,
  input  logic        ws_eret,
  input  logic        c0_status_ie,
  input  logic        c0_status_exl,
  input  logic [7:0]  c0_status_im,
  input  logic [7:0]  c0_cause_ip,
  input  logic [31:0] c0_epc,
  output logic        wb_ex,
  output logic        wb_eret,
  output logic [4:0]  wb_excode,
  output logic        wb_bd,
  output logic [31:0] wb_epc,
  output logic [31:0] wb_badvaddr,
  output logic        wb_badvaddr_we,
  output logic        exc_flush,
  output logic        ws_block,
  exc_ctrl_if.master  redir
`ifdef EXC_CTRL_STAT_EN
  ,
  output logic [15:0] exc_count,
  output logic [15:0] int_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // With a single flush cycle the entry cycle is the whole flush.
  localparam bit         ONE_CYCLE     = (FLUSH_CYCLES <= 1);
  localparam logic [3:0] FLUSH_LAST_M1 = 4'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] tgt_q, tgt_d;

  logic        int_req;
  logic        take;
  logic        hit;
  logic        is_int;
  logic [4:0]  code;
  logic        bva_we;
  logic [31:0] bva;

  // Priority encoder over the candidate events.
  always_comb begin
    int_req = (|(c0_cause_ip & c0_status_im)) & c0_status_ie & ~c0_status_exl;
    // Gating with resetn keeps every output at 0 while reset is asserted.
    take    = (state_q == ST_IDLE) & ws_valid & resetn;
    hit     = 1'b1;
    is_int  = 1'b0;
    code    = 5'h00;
    bva_we  = 1'b0;
    bva     = 32'h0;
    if (int_req) begin
      is_int = 1'b1;
    end else if (ws_ex_adel_if) begin
      code   = 5'h04;
      bva_we = 1'b1;
      bva    = ws_pc;
    end else if (ws_ex_ri) begin
      code = 5'h0a;
    end else if (ws_ex_ov) begin
      code = 5'h0c;
    end else if (ws_ex_sys) begin
      code = 5'h08;
    end else if (ws_ex_bp) begin
      code = 5'h09;
    end else if (ws_ex_adel) begin
      code   = 5'h04;
      bva_we = 1'b1;
      bva    = ws_data_addr;
    end else if (ws_ex_ades) begin
      code   = 5'h05;
      bva_we = 1'b1;
      bva    = ws_data_addr;
    end else begin
      hit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      tgt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    tgt_d                = tgt_q;
    wb_ex                = 1'b0;
    wb_eret              = 1'b0;
    wb_excode            = 5'h00;
    wb_bd                = 1'b0;
    wb_epc               = 32'h0;
    wb_badvaddr          = 32'h0;
    wb_badvaddr_we       = 1'b0;
    exc_flush            = 1'b0;
    ws_block             = 1'b0;
    redir.redirect_valid = 1'b0;
    redir.redirect_pc    = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (take && (hit || ws_eret)) begin
          exc_flush = 1'b1;
          if (hit) begin
            // An interrupt also swallows a coincident eret.
            wb_ex          = 1'b1;
            wb_excode      = code;
            wb_bd          = ws_bd;
            wb_epc         = ws_bd ? (ws_pc - 32'd4) : ws_pc;
            wb_badvaddr    = bva;
            wb_badvaddr_we = bva_we;
            ws_block       = 1'b1;
            tgt_d          = EXC_VEC;
          end else begin
            wb_eret = 1'b1;
            tgt_d   = c0_epc;
          end
          if (ONE_CYCLE) begin
            state_d = ST_REDIRECT;
          end else begin
            state_d = ST_FLUSH;
            cnt_d   = 4'd1;
          end
        end
      end

      ST_FLUSH: begin
        exc_flush = 1'b1;
        ws_block  = 1'b1;
        if (cnt_q == FLUSH_LAST_M1) begin
          state_d = ST_REDIRECT;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_REDIRECT: begin
        ws_block             = 1'b1;
        redir.redirect_valid = 1'b1;
        redir.redirect_pc    = tgt_q;
        if (redir.redirect_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

`ifdef EXC_CTRL_STAT_EN
  logic [15:0] exc_cnt_q;
  logic [15:0] int_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exc_cnt_q <= 16'h0;
      int_cnt_q <= 16'h0;
    end else begin
      if (wb_ex && (exc_cnt_q != 16'hffff)) begin
        exc_cnt_q <= exc_cnt_q + 16'd1;
      end
      if (wb_ex && is_int && (int_cnt_q != 16'hffff)) begin
        int_cnt_q <= int_cnt_q + 16'd1;
      end
    end
  end

  assign exc_count = exc_cnt_q;
  assign int_count = int_cnt_q;
`endif

endmodule
